serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_pkg.sv | 13 +
 rtl/serial_add_ctrl_if.sv | 45 ++++
 rtl/fa_cell.sv | 17 +
 rtl/serial_add_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
// Contents: FSM state encoding and the default operand width.
package serial_add_pkg;

    localparam int unsigned DEFAULT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Handshake bundle between the operand producer / result consumer and serial_add_ctrl.
// Producer side: in_valid, a, b, cin (and sub when SERIAL_ADD_SUB_EN is defined) -> in_ready.
// Consumer side: out_ready -> out_valid, sum, cout. Status: busy.
// master = producer/consumer (testbench or surrounding logic); slave = the adder block.
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) ();

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`endif

endinterface

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder, time-shared across all bit positions.
// Ports: x, y, ci (inputs); s = sum bit, co = carry out.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = x ^ y;
    assign s  = p ^ ci;
    assign co = (x & y) | (ci & p);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: adds two W-bit operands LSB-first over W cycles
// using one full-adder cell, with valid/ready handshakes on input and output.
// Ports: clk, rst_n (synchronous, active-low), bus (serial_add_ctrl_if.slave).
// Optional macro SERIAL_ADD_SUB_EN: adds bus.sub; when set at accept, computes a-b
// (b inverted, carry-in forced to 1, cout=1 means no borrow).
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_add_ctrl_if.slave     bus
);

    localparam int unsigned CW = $clog2(W);

    state_e         state_q;
    logic [W-1:0]   a_sh_q;
    logic [W-1:0]   b_sh_q;
    logic [W-1:0]   sum_sh_q;
    logic [W-1:0]   sum_q;
    logic           carry_q;
    logic           cout_q;
    logic [CW-1:0]  cnt_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic           busy_q;

    logic           fa_s;
    logic           fa_co;
    logic [W-1:0]   sum_sh_d;
    logic [W-1:0]   b_cap_c;
    logic           carry_cap_c;

    fa_cell u_fa (
        .x  (a_sh_q[0]),
        .y  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB so bit 0 ends up at the LSB after W shifts.
    assign sum_sh_d = {fa_s, sum_sh_q[W-1:1]};

    // Operand B / carry-in as loaded at accept time.
`ifdef SERIAL_ADD_SUB_EN
    assign b_cap_c     = bus.sub ? ~bus.b : bus.b;
    assign carry_cap_c = bus.sub ? 1'b1   : bus.cin;
`else
    assign b_cap_c     = bus.b;
    assign carry_cap_c = bus.cin;
`endif

    // Sequencer FSM with datapath shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_sh_q    <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_sh_q     <= bus.a;
                        b_sh_q     <= b_cap_c;
                        carry_q    <= carry_cap_c;
                        sum_sh_q   <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    sum_sh_q <= sum_sh_d;
                    carry_q  <= fa_co;
                    // Counter stops at W-1 so it never wraps.
                    if (cnt_q == CW'(W - 1)) begin
                        sum_q       <= sum_sh_d;
                        cout_q      <= fa_co;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (W=8): directed cases, backpressure,
// mid-operation reset, back-to-back handshakes and randomized operands checked
// against an arithmetic reference model. Subtract cases build with SERIAL_ADD_SUB_EN.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    serial_add_ctrl_if #(.W(W)) bus ();

    serial_add_ctrl #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: {cout,sum} = a + b + cin, or a + ~b + 1 when subtracting.
    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic ms);
        logic [W-1:0] nb;
        nb = ~mb;
        if (ms)
            return {1'b0, ma} + {1'b0, nb} + (W+1)'(1);
        return {1'b0, ma} + {1'b0, mb} + (W+1)'(mc);
    endfunction

    task automatic drive_ops(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                             input logic tc, input logic ts);
        bus.a   = ta;
        bus.b   = tb_v;
        bus.cin = tc;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub = ts;
`endif
    endtask

    // One full transaction; called at a negedge with the DUT idle.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tc, input logic ts, input int hold);
        logic [W:0] e;
        int lat;
        e = model(ta, tb_v, tc, ts);
        check("in_ready_idle", 64'(bus.in_ready), 64'(1));
        bus.out_ready = (hold == 0);
        bus.in_valid  = 1'b1;
        drive_ops(ta, tb_v, tc, ts);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        drive_ops(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        check("busy_run", 64'(bus.busy), 64'(1));
        check("in_ready_run", 64'(bus.in_ready), 64'(0));
        lat = 0;
        while (!bus.out_valid && lat < int'(W) + 4) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(W));
        check("sum", 64'(bus.sum), 64'(e[W-1:0]));
        check("cout", 64'(bus.cout), 64'(e[W]));
        check("busy_done", 64'(bus.busy), 64'(0));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_out_valid", 64'(bus.out_valid), 64'(1));
            check("bp_sum", 64'(bus.sum), 64'(e[W-1:0]));
            check("bp_cout", 64'(bus.cout), 64'(e[W]));
            check("bp_in_ready", 64'(bus.in_ready), 64'(0));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_out_valid", 64'(bus.out_valid), 64'(0));
        check("post_in_ready", 64'(bus.in_ready), 64'(1));
        check("post_sum_hold", 64'(bus.sum), 64'(e[W-1:0]));
    endtask

    logic [W-1:0] ba [3];
    logic [W-1:0] bb [3];
    logic         bc [3];
    logic [W:0]   be [3];
    int           acc_cyc [3];

    initial begin
        int  acc_n;
        int  res_n;
        logic accepted;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive_ops('0, '0, 1'b0, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_sum", 64'(bus.sum), 64'(0));
        check("rst_cout", 64'(bus.cout), 64'(0));

        // Directed values
        do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0);
        check("dir_5a_3c", 64'(bus.sum), 64'(8'h96));
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        check("dir_ff_01_cout", 64'(bus.cout), 64'(1));
        do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0);
        check("dir_ff_ff_1", 64'(bus.sum), 64'(8'hFF));

        // Backpressure
        do_op(8'h81, 8'h7F, 1'b1, 1'b0, 5);

        // Reset mid-operation at RUN bit 3
        bus.in_valid = 1'b1;
        drive_ops(8'hA5, 8'h5A, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("mid_rst_busy", 64'(bus.busy), 64'(0));
        check("mid_rst_sum", 64'(bus.sum), 64'(0));
        check("mid_rst_cout", 64'(bus.cout), 64'(0));
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'(1));
        for (int i = 0; i < int'(W) + 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("mid_rst_no_pulse", 64'(bus.out_valid), 64'(0));
        end
        do_op(8'h01, 8'h02, 1'b0, 1'b0, 0);
        check("after_rst_sum", 64'(bus.sum), 64'(8'h03));

        // Back-to-back with in_valid held high
        for (int i = 0; i < 3; i++) begin
            ba[i] = W'($urandom);
            bb[i] = W'($urandom);
            bc[i] = 1'($urandom);
            be[i] = model(ba[i], bb[i], bc[i], 1'b0);
            acc_cyc[i] = -1;
        end
        acc_n = 0;
        res_n = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        drive_ops(ba[0], bb[0], bc[0], 1'b0);
        for (int c = 0; c < 60 && res_n < 3; c++) begin
            accepted = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                check("b2b_sum", 64'(bus.sum), 64'(be[res_n][W-1:0]));
                check("b2b_cout", 64'(bus.cout), 64'(be[res_n][W]));
                res_n++;
            end
            @(posedge clk);
            @(negedge clk);
            if (accepted) begin
                acc_cyc[acc_n] = c;
                acc_n++;
                if (acc_n < 3)
                    drive_ops(ba[acc_n], bb[acc_n], bc[acc_n], 1'b0);
                else
                    bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        check("b2b_results", 64'(res_n), 64'(3));
        check("b2b_accepts", 64'(acc_n), 64'(3));
        check("b2b_ii_1", 64'(acc_cyc[1] - acc_cyc[0]), 64'(W + 2));
        check("b2b_ii_2", 64'(acc_cyc[2] - acc_cyc[1]), 64'(W + 2));
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end

`ifdef SERIAL_ADD_SUB_EN
        // Subtraction
        do_op(8'h10, 8'h01, 1'b0, 1'b1, 0);
        check("sub_10_01", 64'({bus.cout, bus.sum}), 64'(9'h10F));
        do_op(8'h01, 8'h02, 1'b1, 1'b1, 0);
        check("sub_01_02", 64'({bus.cout, bus.sum}), 64'(9'h0FF));
`endif

        // Randomized operands and backpressure
        for (int i = 0; i < 20; i++) begin
            logic rs;
`ifdef SERIAL_ADD_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            do_op(W'($urandom), W'($urandom), 1'($urandom), rs, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
